// File: rtl/cache_ctrl_pkg.sv
// Shared types and sizing helpers for the cache access controller.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    CREAD  = 3'd2,
    MREAD  = 3'd3,
    MWRITE = 3'd4,
    FILL   = 3'd5,
    RESP   = 3'd6
  } state_e;

  localparam int STATE_W = 3;

  function automatic int index_w(input int cache_size);
    return (cache_size > 1) ? $clog2(cache_size) : 1;
  endfunction

  function automatic int tag_w(input int addr_width, input int cache_size);
    return addr_width - index_w(cache_size);
  endfunction

  function automatic int id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/cache_access_ctrl_rr_arbiter.sv
// Round-robin arbiter: the search starts at i_ptr and wraps, first requester found wins.
module rr_arbiter
  import cache_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int ID_W = id_w(NUM_REQ)
) (
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_id
);

  logic [ID_W-1:0] w_idx;
  logic            w_found;

  always_comb begin
    o_gnt   = '0;
    o_id    = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_idx = ID_W'((int'(i_ptr) + off) % NUM_REQ);
      if (i_en && !w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_id         = w_idx;
      end
    end
  end

endmodule

// File: rtl/cache_access_ctrl.sv
// Shares one direct-mapped cache among NUM_REQ requesters; owns tag/valid state,
// fills misses from backing memory, write-through with write-allocate.
module cache_access_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int CACHE_SIZE = 16,
  parameter int NUM_REQ    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          c_cs,
  output logic                          c_we,
  output logic                          c_oe,
  output logic [ADDR_WIDTH-1:0]         c_addr,
  output logic [DATA_WIDTH-1:0]         c_wdata,
  input  logic [DATA_WIDTH-1:0]         c_rdata,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic                          mem_ack,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic [STATE_W-1:0]            dbg_state
);

  localparam int INDEX_W = index_w(CACHE_SIZE);
  localparam int TAG_W   = tag_w(ADDR_WIDTH, CACHE_SIZE);
  localparam int ID_W    = id_w(NUM_REQ);

  // Handshakes: req[i] is held by the requester until gnt[i] pulses; mem_req is
  // held by this block until a one-cycle mem_ack, which is ignored in other states.

  state_e                r_state;
  logic [NUM_REQ-1:0]    r_gnt;
  logic [NUM_REQ-1:0]    r_sel;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [ID_W-1:0]       r_id;
  logic [ID_W-1:0]       r_rr_ptr;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_flush_pend;
  logic [CACHE_SIZE-1:0] r_valid;
  logic [TAG_W-1:0]      r_tag [CACHE_SIZE];

  logic                  r_c_cs;
  logic                  r_c_we;
  logic                  r_c_oe;
  logic [ADDR_WIDTH-1:0] r_c_addr;
  logic [DATA_WIDTH-1:0] r_c_wdata;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  logic                  w_arb_en;
  logic [NUM_REQ-1:0]    w_arb_gnt;
  logic [ID_W-1:0]       w_arb_id;
  logic [INDEX_W-1:0]    w_index;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit;
  logic [ID_W-1:0]       w_next_ptr;

  // Arbitration only happens in IDLE with no flush outstanding, so requests wait out a flush.
  assign w_arb_en   = (r_state == IDLE) && !flush && !r_flush_pend;
  assign w_index    = r_addr[INDEX_W-1:0];
  assign w_tag      = r_addr[ADDR_WIDTH-1:INDEX_W];
  assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_next_ptr = (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .i_en  (w_arb_en),
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt),
    .o_id  (w_arb_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_gnt        <= '0;
      r_sel        <= '0;
      r_rsp_valid  <= '0;
      r_rsp_rdata  <= '0;
      r_id         <= '0;
      r_rr_ptr     <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_flush_pend <= 1'b0;
      r_valid      <= '0;
      for (int i = 0; i < CACHE_SIZE; i++) r_tag[i] <= '0;
      r_c_cs       <= 1'b0;
      r_c_we       <= 1'b0;
      r_c_oe       <= 1'b0;
      r_c_addr     <= '0;
      r_c_wdata    <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      if (flush && (r_state != IDLE)) r_flush_pend <= 1'b1;

      case (r_state)
        IDLE: begin
          if (flush || r_flush_pend) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
          end else if (|w_arb_gnt) begin
            r_gnt   <= w_arb_gnt;
            r_sel   <= w_arb_gnt;
            r_id    <= w_arb_id;
            r_we    <= req_we[w_arb_id];
            r_addr  <= req_addr[int'(w_arb_id)*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata <= req_wdata[int'(w_arb_id)*DATA_WIDTH +: DATA_WIDTH];
            r_state <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (r_we) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_wdata;
            r_state     <= MWRITE;
          end else if (w_hit) begin
            r_c_cs   <= 1'b1;
            r_c_oe   <= 1'b1;
            r_c_addr <= r_addr;
            r_state  <= CREAD;
          end else begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= '0;
            r_state     <= MREAD;
          end
        end

        CREAD: begin
          r_rdata     <= c_rdata;
          r_c_cs      <= 1'b0;
          r_c_oe      <= 1'b0;
          r_c_addr    <= '0;
          r_rsp_valid <= r_sel;
          r_rsp_rdata <= c_rdata;
          r_state     <= RESP;
        end

        MREAD, MWRITE: begin
          if (mem_ack) begin
            r_rdata     <= mem_rdata;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_c_cs      <= 1'b1;
            r_c_we      <= 1'b1;
            r_c_addr    <= r_addr;
            r_c_wdata   <= r_we ? r_wdata : mem_rdata;
            r_state     <= FILL;
          end
        end

        // The fill marks the line valid even if a flush arrived meanwhile;
        // the pending flush clears it again once back in IDLE.
        FILL: begin
          r_tag[w_index]   <= w_tag;
          r_valid[w_index] <= 1'b1;
          r_c_cs           <= 1'b0;
          r_c_we           <= 1'b0;
          r_c_addr         <= '0;
          r_c_wdata        <= '0;
          r_rsp_valid      <= r_sel;
          r_rsp_rdata      <= r_we ? '0 : r_rdata;
          r_state          <= RESP;
        end

        RESP: begin
          r_rr_ptr <= w_next_ptr;
          r_state  <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign c_cs      = r_c_cs;
  assign c_we      = r_c_we;
  assign c_oe      = r_c_oe;
  assign c_addr    = r_c_addr;
  assign c_wdata   = r_c_wdata;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_cache_access_ctrl.sv
// Directed bench for cache_access_ctrl with a behavioural cache array and hand-driven memory acks.
module tb_cache_access_ctrl;

  localparam int S_IDLE   = 0;
  localparam int S_LOOKUP = 1;
  localparam int S_CREAD  = 2;
  localparam int S_MREAD  = 3;
  localparam int S_MWRITE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  req_we = '0;
  logic [31:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  gnt;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        c_cs;
  logic        c_we;
  logic        c_oe;
  logic [15:0] c_addr;
  logic [7:0]  c_wdata;
  logic [7:0]  c_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  logic [7:0] cmem [16];

  cache_access_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .c_cs      (c_cs),
    .c_we      (c_we),
    .c_oe      (c_oe),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_rdata   (c_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // behavioural cache data array
  always @(posedge clk) begin
    if (c_cs && c_we) cmem[c_addr[3:0]] <= c_wdata;
  end
  always_comb begin
    c_rdata = 8'h00;
    if (c_cs && c_oe) c_rdata = cmem[c_addr[3:0]];
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      assert (!(c_we && c_oe)) else begin
        failures++;
        $error("FAIL we_oe_excl observed=%0b%0b expected=not_both", c_we, c_oe);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input int id, input bit we, input logic [15:0] addr, input logic [7:0] wdata);
    req[id] = 1'b1;
    req_we[id] = we;
    req_addr[id*16 +: 16] = addr;
    req_wdata[id*8 +: 8] = wdata;
  endtask

  // Walks one transaction whose request is sampled at the next rising edge.
  task automatic run_granted(input int id, input bit we, input logic [15:0] addr,
                             input logic [7:0] wdata, input bit miss, input logic [7:0] mrdata,
                             input logic [7:0] exp_rdata, input bit flush_mid);
    step();
    check("gnt", {30'd0, gnt}, 32'd1 << id);
    check("state_lookup", {29'd0, dbg_state}, S_LOOKUP);
    req[id] = 1'b0;
    step();
    if (!miss) begin
      check("cread_ctl", {29'd0, c_cs, c_oe, c_we}, 32'b110);
      check("cread_addr", {16'd0, c_addr}, {16'd0, addr});
      check("hit_no_mem_req", {31'd0, mem_req}, 0);
      check("state_cread", {29'd0, dbg_state}, S_CREAD);
    end else begin
      check("mem_req", {30'd0, mem_req, mem_we}, {30'd0, 1'b1, we});
      check("mem_addr", {16'd0, mem_addr}, {16'd0, addr});
      check("state_mem", {29'd0, dbg_state}, we ? S_MWRITE : S_MREAD);
      if (we) check("mem_wdata", {24'd0, mem_wdata}, {24'd0, wdata});
      if (flush_mid) flush = 1'b1;
      step();
      flush = 1'b0;
      check("mem_req_held1", {31'd0, mem_req}, 1);
      step();
      check("mem_req_held2", {31'd0, mem_req}, 1);
      mem_ack = 1'b1;
      mem_rdata = mrdata;
      step();
      mem_ack = 1'b0;
      mem_rdata = 8'h00;
      check("fill_ctl", {28'd0, c_cs, c_we, c_oe, mem_req}, 32'b1100);
      check("fill_addr", {16'd0, c_addr}, {16'd0, addr});
      check("fill_data", {24'd0, c_wdata}, {24'd0, we ? wdata : mrdata});
    end
    step();
    check("rsp_valid", {30'd0, rsp_valid}, 32'd1 << id);
    check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rdata});
    step();
    check("rsp_done", {30'd0, rsp_valid}, 0);
    check("back_idle", {29'd0, dbg_state}, S_IDLE);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) cmem[i] = 8'h00;

    // reset state
    repeat (3) step();
    check("rst_gnt_rsp", {28'd0, gnt, rsp_valid}, 0);
    check("rst_cache_pins", {5'd0, c_cs, c_we, c_oe, c_addr, c_wdata}, 0);
    check("rst_mem_pins", {6'd0, mem_req, mem_we, mem_addr, mem_wdata}, 0);
    check("rst_state_rdata", {21'd0, dbg_state, rsp_rdata}, 0);
    rst = 1'b0;
    step();
    check("idle_after_rst", {29'd0, dbg_state}, S_IDLE);

    // cold read miss, then a hit on the same address
    raise(0, 1'b0, 16'h0004, 8'h00);
    run_granted(0, 1'b0, 16'h0004, 8'h00, 1'b1, 8'hAA, 8'hAA, 1'b0);
    raise(0, 1'b0, 16'h0004, 8'h00);
    run_granted(0, 1'b0, 16'h0004, 8'h00, 1'b0, 8'h00, 8'hAA, 1'b0);

    // write-through with allocate, then a read hit of the written value
    raise(1, 1'b1, 16'h0123, 8'h55);
    run_granted(1, 1'b1, 16'h0123, 8'h55, 1'b1, 8'h00, 8'h00, 1'b0);
    raise(1, 1'b0, 16'h0123, 8'h00);
    run_granted(1, 1'b0, 16'h0123, 8'h00, 1'b0, 8'h00, 8'h55, 1'b0);

    // both requesters; last winner was 1 so requester 0 goes first, 0x0014 evicts index 4
    raise(0, 1'b0, 16'h0014, 8'h00);
    raise(1, 1'b0, 16'h0004, 8'h00);
    run_granted(0, 1'b0, 16'h0014, 8'h00, 1'b1, 8'h3C, 8'h3C, 1'b0);
    run_granted(1, 1'b0, 16'h0004, 8'h00, 1'b1, 8'hAA, 8'hAA, 1'b0);

    // flush in IDLE: request waits a cycle, and the previously valid line misses
    flush = 1'b1;
    raise(1, 1'b0, 16'h0123, 8'h00);
    step();
    flush = 1'b0;
    check("flush_idle_no_gnt", {30'd0, gnt}, 0);
    check("flush_idle_state", {29'd0, dbg_state}, S_IDLE);
    run_granted(1, 1'b0, 16'h0123, 8'h00, 1'b1, 8'h55, 8'h55, 1'b0);

    // flush during MREAD: fill completes, pending flush then invalidates it
    raise(0, 1'b0, 16'h0004, 8'h00);
    run_granted(0, 1'b0, 16'h0004, 8'h00, 1'b1, 8'hAA, 8'hAA, 1'b1);
    raise(0, 1'b0, 16'h0004, 8'h00);
    step();
    check("pend_flush_no_gnt", {30'd0, gnt}, 0);
    run_granted(0, 1'b0, 16'h0004, 8'h00, 1'b1, 8'hAA, 8'hAA, 1'b0);

    // reset while waiting for memory; late ack must be ignored
    raise(0, 1'b0, 16'h0200, 8'h00);
    step();
    check("rstmid_gnt", {30'd0, gnt}, 32'd1);
    req[0] = 1'b0;
    step();
    check("rstmid_mem_req", {31'd0, mem_req}, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_mem_pins", {6'd0, mem_req, mem_we, mem_addr, mem_wdata}, 0);
    check("rstmid_cache_pins", {5'd0, c_cs, c_we, c_oe, c_addr, c_wdata}, 0);
    check("rstmid_rsp", {19'd0, dbg_state, gnt, rsp_valid, rsp_rdata}, 0);
    mem_ack = 1'b1;
    mem_rdata = 8'h77;
    step();
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    check("late_ack_state", {29'd0, dbg_state}, S_IDLE);
    step();
    check("late_ack_no_rsp", {28'd0, rsp_valid, c_cs, mem_req}, 0);
    step();
    check("late_ack_no_rsp2", {30'd0, rsp_valid}, 0);

    // valid bits cleared by reset: previously filled address misses
    raise(0, 1'b0, 16'h0004, 8'h00);
    run_granted(0, 1'b0, 16'h0004, 8'h00, 1'b1, 8'hAA, 8'hAA, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
